// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: payload + valid with stall, flush and sync reset.
// Optional stall performance counters are compiled in with PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
   parameter int               CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   input  logic                 stall,
   input  logic                 flush,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] stall_run,
   output logic [CNT_WIDTH-1:0] max_stall_run
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data  <= RESET_VAL;
         out_valid <= 1'b0;
      end else if (flush) begin
         out_data  <= BUBBLE_VAL;
         out_valid <= 1'b0;
      end else if (!stall) begin
         out_data  <= in_data;
         out_valid <= in_valid;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                 stalled;
   logic [CNT_WIDTH-1:0] cycles_q;
   logic [CNT_WIDTH-1:0] run_q;
   logic [CNT_WIDTH-1:0] max_q;
   logic [CNT_WIDTH-1:0] run_next;

   // A flush overrides a stall, so that cycle is not counted and ends the run.
   assign stalled = stall && !flush;

   // NOTE: every variable written here gets a default first so no latch can be inferred.
   always_comb begin
      run_next = '0;
      if (stalled)
         run_next = (run_q == CNT_MAX) ? run_q : run_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycles_q <= '0;
         run_q    <= '0;
         max_q    <= '0;
      end else begin
         if (stalled && cycles_q != CNT_MAX)
            cycles_q <= cycles_q + 1'b1;
         run_q <= run_next;
         // Compare against the next run length so an in-progress run is reflected.
         if (run_next > max_q)
            max_q <= run_next;
      end
   end

   assign stall_cycles  = cycles_q;
   assign stall_run     = run_q;
   assign max_stall_run = max_q;
`else
   assign stall_cycles  = '0;
   assign stall_run     = '0;
   assign max_stall_run = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (32-bit/16-bit counters, 8-bit/2-bit counters) share
// stimulus; a count-based reference model computes expected payload and counter values.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [31:0] RV_A  = 32'hBFC0_0000;
   localparam logic [31:0] BUB_A = 32'h0000_0000;
   localparam logic [7:0]  RV_B  = 8'h5A;
   localparam logic [7:0]  BUB_B = 8'hA5;

   logic        clk = 1'b0;
   logic        reset, in_valid, stall, flush;
   logic [31:0] in_data;

   logic [31:0] a_data;
   logic        a_valid;
   logic [15:0] a_cyc, a_run, a_max;
   logic [7:0]  b_data;
   logic        b_valid;
   logic [1:0]  b_cyc, b_run, b_max;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: true (unbounded) counts, saturated only when compared.
   logic [31:0] m_data_a;
   logic [7:0]  m_data_b;
   logic        m_valid;
   int          m_cycles, m_run, m_max;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV_A), .BUBBLE_VAL(BUB_A), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .stall(stall), .flush(flush), .out_data(a_data), .out_valid(a_valid),
      .stall_cycles(a_cyc), .stall_run(a_run), .max_stall_run(a_max)
   );

   pipe_stage_reg #(.WIDTH(8), .RESET_VAL(RV_B), .BUBBLE_VAL(BUB_B), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_data[7:0]), .in_valid(in_valid),
      .stall(stall), .flush(flush), .out_data(b_data), .out_valid(b_valid),
      .stall_cycles(b_cyc), .stall_run(b_run), .max_stall_run(b_max)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int sat(input int value, input int bits);
      int top;
      top = (1 << bits) - 1;
      return (value > top) ? top : value;
   endfunction

   task automatic check_all();
      int w;
      w = PERF ? 1 : 0;
      check("a_data",  64'(a_data),  64'(m_data_a));
      check("a_valid", 64'(a_valid), 64'(m_valid));
      check("b_data",  64'(b_data),  64'(m_data_b));
      check("b_valid", 64'(b_valid), 64'(m_valid));
      check("a_stall_cycles",  64'(a_cyc), 64'(w * sat(m_cycles, 16)));
      check("a_stall_run",     64'(a_run), 64'(w * sat(m_run, 16)));
      check("a_max_stall_run", 64'(a_max), 64'(w * sat(m_max, 16)));
      check("b_stall_cycles",  64'(b_cyc), 64'(w * sat(m_cycles, 2)));
      check("b_stall_run",     64'(b_run), 64'(w * sat(m_run, 2)));
      check("b_max_stall_run", 64'(b_max), 64'(w * sat(m_max, 2)));
   endtask

   // One clock: drive on the falling edge, update the model at the rising edge, check 1 time unit later.
   task automatic step(input logic r, input logic s, input logic f, input logic [31:0] d, input logic v);
      @(negedge clk);
      reset = r; stall = s; flush = f; in_data = d; in_valid = v;
      @(posedge clk);
      if (r) begin
         m_data_a = RV_A; m_data_b = RV_B; m_valid = 1'b0;
         m_cycles = 0; m_run = 0; m_max = 0;
      end else begin
         if (f) begin
            m_data_a = BUB_A; m_data_b = BUB_B; m_valid = 1'b0; m_run = 0;
         end else if (s) begin
            m_cycles++; m_run++;
         end else begin
            m_data_a = d; m_data_b = d[7:0]; m_valid = v; m_run = 0;
         end
         if (m_run > m_max) m_max = m_run;
      end
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0;

      // Reset held two cycles, then a load of 4.
      step(1, 0, 0, 32'h0, 0);
      step(1, 1, 0, 32'h77, 1);
      step(0, 0, 0, 32'd4, 1);

      // Stall hold: load 8, stall 3 cycles with 12 presented, release.
      step(0, 0, 0, 32'd8, 1);
      repeat (3) step(0, 1, 0, 32'd12, 1);
      step(0, 0, 0, 32'd12, 1);

      // Flush with stall: bubble loaded, run cleared, stall count unchanged.
      step(0, 1, 1, 32'd16, 1);

      // Max tracking: runs of 2, 5, 1 separated by loads, from a clean reset.
      step(1, 0, 0, 32'h0, 0);
      step(0, 0, 0, 32'h100, 1);
      repeat (2) step(0, 1, 0, 32'h104, 1);
      step(0, 0, 0, 32'h104, 1);
      repeat (5) step(0, 1, 0, 32'h108, 0);
      step(0, 0, 0, 32'h108, 0);
      repeat (1) step(0, 1, 0, 32'h10C, 1);
      step(0, 0, 0, 32'h10C, 1);

      // Saturation on the narrow counters: six stalls in a row, then reset mid-stall.
      repeat (6) step(0, 1, 0, 32'hDEAD_BEEF, 1);
      step(1, 1, 0, 32'h55, 1);
      step(0, 1, 0, 32'h55, 1);

      // Randomized traffic with occasional reset and flush.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 7) == 0), $urandom, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the five-stage MIPS core; it replaces the per-stage fixed-width PC/field registers starting with the fetch stage. It captures one stage's payload plus a valid bit on each clock edge. It supports stall (hold), flush (bubble insertion) and a synchronous reset to a configurable value. Optional performance counters track stall activity for pipeline-hazard analysis.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (1..64)
- RESET_VAL, 0, out_data value after reset (e.g. PC reset vector)
- BUBBLE_VAL, 0, out_data value loaded on flush (0 = MIPS nop)
- CNT_WIDTH, 16, width of performance counters (2..32)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_data  in  WIDTH  next-stage payload (e.g. f_valP)
- in_valid  in  1  payload is a real instruction
- stall  in  1  hold current contents
- flush  in  1  replace contents with a bubble
- out_data  out  WIDTH  registered payload (e.g. F_valP)
- out_valid  out  1  registered valid
- stall_cycles  out  CNT_WIDTH  total stalled cycles, saturating
- stall_run  out  CNT_WIDTH  length of the current consecutive stall run, saturating
- max_stall_run  out  CNT_WIDTH  longest completed-or-current stall run, saturating

## Operation
- Per-edge priority: reset > flush > stall > load.
- reset: out_data=RESET_VAL, out_valid=0, all counters=0.
- flush (regardless of stall): out_data=BUBBLE_VAL, out_valid=0.
- stall (flush=0): out_data and out_valid hold.
- load (stall=0, flush=0): out_data=in_data, out_valid=in_valid.
- Counters (macro enabled), evaluated on each non-reset edge:
  - A stalled cycle is stall=1 and flush=0.
  - stall_cycles: +1 per stalled cycle; saturates at 2^CNT_WIDTH-1.
  - stall_run: +1 per stalled cycle (saturating); cleared to 0 on any non-stalled cycle, including flush.
  - max_stall_run: updated to max(max_stall_run, next stall_run) on every edge, so it tracks a run while it is in progress.
- Stall and flush are honoured identically whether out_valid is 0 or 1. Stalling a bubble is legal and counted.
- in_valid/in_data are ignored except on load cycles.

## Timing
- Latency 1 cycle: in_data sampled at edge N appears on out_data after edge N.
- All outputs are registered; there is no combinational path from input to output.
- Reset mid-stall: the next edge clears the payload and all counters; a stall asserted in the same cycle as reset is ignored.
- Flush in the same cycle as stall: the bubble is loaded and stall_run is cleared.
- Counter saturation: once a counter reaches all-ones it stays there until reset. There is no wrap.
- Deassertion of reset: the first non-reset edge behaves normally (a load if stall=0).

## Configuration
- Macro PIPE_STAGE_PERF_EN.
- Defined: counter logic is compiled in as described.
- Undefined: no counter flops exist. stall_cycles, stall_run and max_stall_run are tied to 0. Payload and valid behaviour is identical.

## Test plan
- Reset/load: WIDTH=32, RESET_VAL=32'hBFC00000. Hold reset for 2 cycles: out_data=BFC00000, out_valid=0. Then present in_data=4, in_valid=1, stall=0: after one edge, out_data=4 and out_valid=1.
- Stall hold: load 8, then hold stall=1 for 3 cycles with in_data=12: out_data stays 8. Release stall: next edge gives out_data=12. With macro enabled, stall_cycles=3, stall_run returns to 0 and max_stall_run=3.
- Flush priority: with out_data=12, assert stall=1 and flush=1 together, in_data=16: next edge gives out_data=BUBBLE_VAL(0), out_valid=0, stall_run=0 and stall_cycles unchanged.
- Max tracking: stall runs of 2, then 5, then 1 cycles separated by loads: max_stall_run=5 and stall_cycles=8.
- Saturation: CNT_WIDTH=2, stall held for 6 cycles: stall_cycles=3, stall_run=3, max_stall_run=3, with no wrap to 0.
- Macro off: repeat the stall-hold scenario without PIPE_STAGE_PERF_EN: payload results are identical and all three counter outputs read 0 throughout.
